// File: rtl/bombe_rotor_stepper.sv
// rtl/bombe_rotor_stepper.sv - three-rotor odometer sweep stepped by the slow tick, halting on hit/stop/end
module bombe_rotor_stepper #(
    parameter int ROTOR_SIZE = 26
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       hit,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    output logic       running,
    output logic       found,
    output logic       done
);

    localparam logic [4:0] MAX = 5'(ROTOR_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FOUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic       tick_q;
    logic       skip, skip_n;
    logic [4:0] l_q, m_q, r_q;
    logic [4:0] l_n, m_n, r_n;
    logic       step;
    logic       at_last;

    assign step    = tick & ~tick_q;
    assign at_last = (l_q == MAX) && (m_q == MAX) && (r_q == MAX);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state  <= S_IDLE;
            tick_q <= 1'b1;
            skip   <= 1'b0;
            l_q    <= 5'd0;
            m_q    <= 5'd0;
            r_q    <= 5'd0;
        end else begin
            state  <= state_n;
            tick_q <= tick;
            skip   <= skip_n;
            l_q    <= l_n;
            m_q    <= m_n;
            r_q    <= r_n;
        end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip;
        l_n     = l_q;
        m_n     = m_q;
        r_n     = r_q;
        if (stop) begin
            // Abort from any state; positions stay where the operator stopped them.
            state_n = S_IDLE;
            skip_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n = S_RUN;
                        skip_n  = 1'b0;
                        l_n     = 5'd0;
                        m_n     = 5'd0;
                        r_n     = 5'd0;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        skip_n = 1'b0;
                        if (hit && !skip) begin
                            state_n = S_FOUND;
                        end else if (at_last) begin
                            state_n = S_DONE;
                        end else if (r_q != MAX) begin
                            r_n = r_q + 5'd1;
                        end else begin
                            r_n = 5'd0;
                            if (m_q != MAX) begin
                                m_n = m_q + 5'd1;
                            end else begin
                                m_n = 5'd0;
                                l_n = l_q + 5'd1;
                            end
                        end
                    end
                end
                S_FOUND: begin
                    // Resume skips the hit still asserted for the found position.
                    if (start) begin
                        state_n = S_RUN;
                        skip_n  = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign pos_l   = l_q;
    assign pos_m   = m_q;
    assign pos_r   = r_q;
    assign running = (state == S_RUN);
    assign found   = (state == S_FOUND);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// tb/tb_bombe_rotor_stepper.sv - scoreboard bench for bombe_rotor_stepper at ROTOR_SIZE 26 and 4
module tb_bombe_rotor_stepper;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       tick   = 1'b1;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       hit    = 1'b0;

    logic [4:0] a_l, a_m, a_r, b_l, b_m, b_r;
    logic       a_run, a_fnd, a_dn, b_run, b_fnd, b_dn;

    typedef struct {
        string       tag;
        bit          sel;
        logic [17:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   idx;

    always #5 clk_in = ~clk_in;

    bombe_rotor_stepper #(.ROTOR_SIZE(26)) dut26 (
        .clk_in(clk_in), .reset(reset), .tick(tick), .start(start), .stop(stop), .hit(hit),
        .pos_l(a_l), .pos_m(a_m), .pos_r(a_r), .running(a_run), .found(a_fnd), .done(a_dn)
    );

    bombe_rotor_stepper #(.ROTOR_SIZE(4)) dut4 (
        .clk_in(clk_in), .reset(reset), .tick(tick), .start(start), .stop(stop), .hit(hit),
        .pos_l(b_l), .pos_m(b_m), .pos_r(b_r), .running(b_run), .found(b_fnd), .done(b_dn)
    );

    function automatic logic [17:0] ev(int i, int n, bit ru, bit fo, bit dn);
        logic [4:0] l, m, r;
        l = 5'(i / (n * n));
        m = 5'((i / n) % n);
        r = 5'(i % n);
        return {l, m, r, ru, fo, dn};
    endfunction

    function automatic logic [17:0] observed(bit sel);
        if (sel) return {b_l, b_m, b_r, b_run, b_fnd, b_dn};
        return {a_l, a_m, a_r, a_run, a_fnd, a_dn};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(string tag, bit sel, logic [17:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, 32'(observed(e.sel)), 32'(e.v));
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_check(string tag, bit sel, logic [17:0] v);
        push(tag, sel, v);
        cyc();
        pop_check();
    endtask

    task automatic tick_step(string tag, bit sel, logic [17:0] v);
        tick = 1'b1;
        drive_check(tag, sel, v);
        tick = 1'b0;
        cyc();
    endtask

    task automatic advance_to(int target);
        while (idx < target) begin
            idx++;
            tick_step("sweep", 1'b0, ev(idx, 26, 1, 0, 0));
        end
    endtask

    initial begin
        // Reset with tick held high; no step may follow release.
        cyc();
        drive_check("reset26", 1'b0, ev(0, 26, 0, 0, 0));
        push("reset4", 1'b1, ev(0, 4, 0, 0, 0));
        pop_check();
        reset = 1'b0;
        drive_check("idle_tick_high", 1'b0, ev(0, 26, 0, 0, 0));
        start = 1'b1;
        push("start", 1'b0, ev(0, 26, 1, 0, 0));
        cyc();
        start = 1'b0;
        pop_check();
        drive_check("tick_still_high", 1'b0, ev(0, 26, 1, 0, 0));
        tick = 1'b0;
        cyc();
        idx = 1;
        tick_step("first_step", 1'b0, ev(1, 26, 1, 0, 0));

        // Carries into pos_m and pos_l.
        advance_to(25);
        idx = 26;
        tick_step("carry_m", 1'b0, ev(26, 26, 1, 0, 0));
        advance_to(675);
        idx = 676;
        tick_step("carry_l", 1'b0, ev(676, 26, 1, 0, 0));

        // Tick held high for five cycles gives exactly one increment.
        idx = 677;
        tick = 1'b1;
        for (int k = 0; k < 5; k++) drive_check("long_tick", 1'b0, ev(677, 26, 1, 0, 0));
        tick = 1'b0;
        cyc();

        // Hit, hold, resume past the found position, refind.
        advance_to(2222);
        hit = 1'b1;
        tick_step("hit_found", 1'b0, ev(2222, 26, 0, 1, 0));
        tick_step("found_hold", 1'b0, ev(2222, 26, 0, 1, 0));
        start = 1'b1;
        push("resume", 1'b0, ev(2222, 26, 1, 0, 0));
        cyc();
        start = 1'b0;
        pop_check();
        tick_step("skip_step", 1'b0, ev(2223, 26, 1, 0, 0));
        tick_step("refound", 1'b0, ev(2223, 26, 0, 1, 0));
        hit = 1'b0;

        // Stop coinciding with a step at 1,2,3.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        start = 1'b1;
        drive_check("restart", 1'b0, ev(0, 26, 1, 0, 0));
        start = 1'b0;
        idx = 0;
        advance_to(731);
        tick = 1'b1;
        stop = 1'b1;
        push("stop_step", 1'b0, ev(731, 26, 0, 0, 0));
        cyc();
        stop = 1'b0;
        tick = 1'b0;
        pop_check();
        cyc();
        tick_step("idle_hold", 1'b0, ev(731, 26, 0, 0, 0));

        // Start with a step in IDLE loads zeros and discards the step.
        tick = 1'b1;
        start = 1'b1;
        push("start_step", 1'b0, ev(0, 26, 1, 0, 0));
        cyc();
        start = 1'b0;
        pop_check();
        drive_check("no_extra_step", 1'b0, ev(0, 26, 1, 0, 0));
        tick = 1'b0;
        cyc();
        tick_step("after_start", 1'b0, ev(1, 26, 1, 0, 0));
        reset = 1'b1;
        drive_check("reset_mid", 1'b0, ev(0, 26, 0, 0, 0));

        // Full sweep at ROTOR_SIZE 4.
        reset = 1'b0;
        cyc();
        start = 1'b1;
        drive_check("start4", 1'b1, ev(0, 4, 1, 0, 0));
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (k < 64) tick_step("sweep4", 1'b1, ev(k, 4, 1, 0, 0));
            else        tick_step("done4", 1'b1, ev(63, 4, 0, 0, 1));
        end
        tick_step("done_hold", 1'b1, ev(63, 4, 0, 0, 1));
        start = 1'b1;
        drive_check("restart4", 1'b1, ev(0, 4, 1, 0, 0));
        start = 1'b0;

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bombe_rotor_stepper.md
# bombe_rotor_stepper

Steps the bombe's three-rotor search position (left/mid/right, each 0..ROTOR_SIZE-1) once per rising edge of the slow tick from the bombe rate divider. It runs an odometer sweep from 000 to the final position and stops on a comparator hit, on operator stop, or at the end of the sweep. It sits directly downstream of the rate divider and upstream of the rotor/comparator datapath, which reads the positions and returns `hit`.

## Interface
Parameters:
- ROTOR_SIZE, 26, positions per rotor; legal range 2..32.

Ports:
- clk_in  input  1  system clock (CLOCK_50); all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  slow clock level from the rate divider; only its 0→1 transitions are used.
- start  input  1  one-cycle pulse: begin a sweep from 0,0,0 (IDLE/DONE) or resume (FOUND).
- stop  input  1  one-cycle pulse: abort the sweep and hold the positions.
- hit  input  1  comparator result for the current positions; sampled only on a step pulse.
- pos_l, pos_m, pos_r  output  5 each  rotor positions; pos_r is least significant.
- running  output  1  high in RUN.
- found  output  1  high in FOUND.
- done  output  1  high in DONE.

## Operation
- Edge detect: register `tick_q` follows `tick` every cycle. `step = tick & ~tick_q` (internal). `tick_q` resets to 1, so no step occurs if `tick` is already high when reset releases.
- States:
  - IDLE: reset state; positions held; `start` → RUN with positions loaded to 0,0,0.
  - RUN: on `step`:
    - `hit`=1 and skip flag clear → FOUND, positions unchanged.
    - Else, at the final position (all = ROTOR_SIZE-1) → DONE, positions held.
    - Else the odometer increments.
    - `stop` → IDLE.
  - FOUND: positions held; `start` → RUN with skip flag set; `stop` → IDLE.
  - DONE: positions held; `start` → RUN with positions loaded to 0,0,0.
- Skip flag:
  - Set on resume from FOUND.
  - Cleared on the next `step` in RUN, and on reset or `stop`.
  - While set, `hit` is ignored, so the resumed sweep steps past the found position.
- Odometer:
  - pos_r increments.
  - pos_r at ROTOR_SIZE-1 wraps to 0 and carries into pos_m.
  - pos_m wraps the same way and carries into pos_l.
  - Positions never exceed ROTOR_SIZE-1.
- Priority within one cycle: reset > stop > start > step.
  - `stop` with `step` in the same cycle: no increment, go to IDLE.
  - `start` in RUN: ignored.
  - `start` with `step` in IDLE: load 0,0,0 only; that step is discarded.
- Reset mid-sweep: next cycle state is IDLE and positions are 0,0,0.

## Timing
- Reset values:
  - pos_l, pos_m, pos_r = 0.
  - running, found, done = 0.
  - tick_q = 1; skip flag = 0.
- All outputs are registered and decoded directly from state and position registers; no combinational path from any input to any output.
- Step latency: positions update at the first clk_in edge at which `tick`=1 and `tick_q`=0. They are visible one cycle after `tick` rises as sampled.
- Exactly one step per tick rising edge, regardless of how long `tick` stays high.
- `hit` must be valid for the current positions in the cycle where `step` is asserted. The tick period (≥10^6 cycles) gives the datapath ample settling time.
- start/stop act on the edge at which they are sampled; state outputs change in the same edge.
- Full sweep: ROTOR_SIZE^3 positions evaluated. The step count from 0,0,0 to DONE is ROTOR_SIZE^3 (17576 for 26): 17575 increments plus the final DONE step.

## Test plan
- Reset with `tick`=1 held high, then `start` → outputs 0 and state IDLE after reset; after `start`, running=1 and no step until `tick` falls and rises again.
- RUN at 0,0,25, one tick edge with `hit`=0 → positions 0,1,0. At 0,25,25 → 1,0,0. `tick` held high for 5 cycles → exactly one increment.
- RUN at 3,7,12, `hit`=1 on the step → found=1, running=0, positions stay 3,7,12. Then `start` with `hit` still 1 → next step gives 3,7,13 and running=1. The following step with `hit`=1 → FOUND at 3,7,13.
- ROTOR_SIZE=4, no hits, 64 tick edges after `start` → done=1 after the 64th, positions 3,3,3. A further tick leaves them unchanged; `start` → 0,0,0 and running=1.
- `stop` in the same cycle as `step` at 1,2,3 → IDLE, positions 1,2,3, no increment. Reset asserted mid-RUN → 0,0,0 and IDLE next cycle.
